// File: rtl/fifo_pkg.sv
// Shared constants for the 16x8 RAM FIFO controller.
// Sizes, pointer width and default flag thresholds.
package fifo_pkg;
  localparam int RAM_WIDTH = 8;
  localparam int RAM_DEPTH = 16;
  localparam int ADDR_SIZE = 4;
  localparam int PTR_W     = ADDR_SIZE + 1;
  localparam int AF_THR    = 14;
  localparam int AE_THR    = 2;
endpackage

// File: rtl/fifo_ptr.sv
// Wrapping FIFO pointer with one extra wrap bit.
// Increments by one when inc is high.
import fifo_pkg::*;

module fifo_ptr #(
  parameter int W = PTR_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] ptr
);

  // advance on each accepted operation, wrapping naturally
  always_ff @(posedge clk) begin
    if (reset)
      ptr <= '0;
    else if (inc)
      ptr <= ptr + W'(1);
  end

endmodule

// File: rtl/fifo_ctrl_16_8.sv
// FIFO controller driving the 16x8 dual-port RAM.
// Tracks occupancy, flags and read-data valid.
import fifo_pkg::*;

module fifo_ctrl_16_8 #(
  parameter int ram_depth = RAM_DEPTH,
  parameter int addr_size = ADDR_SIZE,
  parameter int af_thr    = AF_THR,
  parameter int ae_thr    = AE_THR
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  logic                 pop,
  output logic                 ram_write,
  output logic                 ram_read,
  output logic [addr_size-1:0] ram_wr_addr,
  output logic [addr_size-1:0] ram_rd_addr,
  output logic                 rd_valid,
  output logic                 full,
  output logic                 empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic [addr_size:0]   count,
  output logic                 overflow,
  output logic                 underflow
);

  logic [addr_size:0] wr_ptr;
  logic [addr_size:0] rd_ptr;
  logic               push_ok;
  logic               pop_ok;

  // flags decode only from the registered count
  assign full         = count == (addr_size+1)'(ram_depth);
  assign empty        = count == '0;
  assign almost_full  = count >= (addr_size+1)'(af_thr);
  assign almost_empty = count <= (addr_size+1)'(ae_thr);

  // reset gates the strobes so nothing reaches the RAM
  assign push_ok = push & ~full & ~reset;
  assign pop_ok  = pop & ~empty & ~reset;

  assign ram_write   = push_ok;
  assign ram_read    = pop_ok;
  assign ram_wr_addr = wr_ptr[addr_size-1:0];
  assign ram_rd_addr = rd_ptr[addr_size-1:0];

  fifo_ptr #(.W(addr_size+1)) u_wr_ptr (
    .clk   (clk),
    .reset (reset),
    .inc   (push_ok),
    .ptr   (wr_ptr)
  );

  fifo_ptr #(.W(addr_size+1)) u_rd_ptr (
    .clk   (clk),
    .reset (reset),
    .inc   (pop_ok),
    .ptr   (rd_ptr)
  );

  // occupancy, read-valid and sticky error state
  always_ff @(posedge clk) begin
    if (reset) begin
      count     <= '0;
      rd_valid  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (addr_size+1)'(1);
        2'b01:   count <= count - (addr_size+1)'(1);
        default: count <= count;
      endcase
      rd_valid <= pop_ok;
      if (push & full)
        overflow <= 1'b1;
      if (pop & empty)
        underflow <= 1'b1;
    end
  end

endmodule

// File: doc/fifo_ctrl_16_8.md
Name: fifo_ctrl_16_8

Overview:
- Synchronous FIFO controller that sits directly upstream of the team's 16x8 dual-port RAM and drives its write/read strobes and addresses.
- Converts a push/pop interface into RAM accesses.
- Tracks occupancy, produces full/empty/threshold flags, and reports when RAM read data is valid.
- Data path is not routed through this block: producer data goes straight to the RAM data_in; the consumer samples RAM data_out when rd_valid=1.

Parameters:
ram_depth, 16, number of RAM entries; power of two
addr_size, 4, log2(ram_depth); RAM address width
af_thr, 14, almost_full asserted when count >= af_thr
ae_thr, 2, almost_empty asserted when count <= ae_thr

Ports:
clk  input  1  single clock; all state changes on posedge
reset  input  1  synchronous, active-high reset
push  input  1  producer write request
pop  input  1  consumer read request
ram_write  output  1  to RAM write; high = accepted push this cycle
ram_read  output  1  to RAM read; high = accepted pop this cycle
ram_wr_addr  output  addr_size  to RAM wr_addr; equals wr_ptr[addr_size-1:0]
ram_rd_addr  output  addr_size  to RAM rd_addr; equals rd_ptr[addr_size-1:0]
rd_valid  output  1  RAM data_out holds popped word this cycle
full  output  1  count == ram_depth
empty  output  1  count == 0
almost_full  output  1  count >= af_thr
almost_empty  output  1  count <= ae_thr
count  output  addr_size+1  current occupancy, 0..ram_depth
overflow  output  1  sticky: push attempted while full
underflow  output  1  sticky: pop attempted while empty

Behaviour:
- Reset (sync, active-high, overrides everything) sets:
  - wr_ptr=0, rd_ptr=0, count=0
  - rd_valid=0, overflow=0, underflow=0
  - hence empty=1, full=0, almost_empty=1, almost_full=0, ram_write=0, ram_read=0
- ram_write and ram_read are held low while reset=1.
- Acceptance is combinational from registered state:
  - push_ok = push & ~full
  - pop_ok = pop & ~empty
- ram_write = push_ok and ram_read = pop_ok, in the same cycle as the request. Addresses are the current pointer values, so the RAM captures them at the same edge.
- Pointers are addr_size+1 bits and increment by 1 on each accepted operation, wrapping naturally (15 -> 0 on the address bits; the MSB toggles on wrap).
- count is updated as follows:
  - push_ok only: +1
  - pop_ok only: -1
  - both or neither: unchanged
- full, empty, almost_full and almost_empty are decoded from registered count, so they change the cycle after the causing edge. No combinational path from push/pop to the flags.
- Simultaneous push and pop:
  - Not full and not empty: both accepted, count unchanged.
  - When full: pop accepted, push rejected (overflow sets).
  - When empty: push accepted, pop rejected (underflow sets).
  - No write-through: a word written this cycle is not readable the same cycle.
- Same-address collision: when both are accepted, the addresses can match only if full or empty, and those cases are excluded above. The RAM therefore never sees a same-address read and write.
- Read latency is 1 cycle:
  - rd_valid is registered as pop_ok and is high exactly one cycle after an accepted pop, aligned with RAM data_out.
  - Back-to-back pops give continuous rd_valid.
- overflow and underflow set on a rejected request and clear only on reset.
- Reset mid-operation:
  - All pending state is dropped.
  - rd_valid is 0 on the cycle after reset even if a pop was accepted on the reset edge. (Pops are not accepted during reset because ram_read is gated.)
- Output registers: count, rd_valid, overflow, underflow.
- Combinational outputs: ram_write, ram_read, addresses, and flags decoded from count.

Decomposition:
- Shared package fifo_pkg holds:
  - constants RAM_WIDTH=8, RAM_DEPTH=16, ADDR_SIZE=4
  - pointer width ADDR_SIZE+1
  - default thresholds
- One natural sub-module, fifo_ptr: a wrapping addr_size+1 pointer register with sync reset and increment enable. It is instantiated twice (write and read).
- RAM plus controller integration is a separate wrapper and is out of scope here.

Test Plan:
- Reset, then 16 pushes with no pops:
  - ram_wr_addr steps 0..15.
  - count reaches 16.
  - almost_full rises the cycle after the 14th push.
  - full=1 after the 16th.
  - A 17th push gives ram_write=0 and overflow=1.
- From full, 16 pops:
  - ram_rd_addr steps 0..15.
  - rd_valid is high cycles 1..16 after the first pop.
  - Popped data reads back in push order.
  - empty=1 at the end.
  - A further pop gives ram_read=0 and underflow=1.
- Wrap-around: push 10, pop 10, push 10:
  - Write addresses run 10..15 then 0..3.
  - count=10.
  - Read order is preserved across the wrap.
- Simultaneous push+pop at count=5 for 20 cycles:
  - count stays 5.
  - rd_valid is continuous.
  - No overflow or underflow.
- Simultaneous push+pop when empty:
  - Only push is accepted: count=1, underflow=1, rd_valid stays 0.
- Simultaneous push+pop when full:
  - Only pop is accepted: count=15, overflow=1.
- Reset asserted at count=7 with pop high:
  - The next cycle shows count=0, empty=1, rd_valid=0, flags cleared.
